// File: rtl/rgb_pkg.sv
// Shared FSM state encoding and channel limits for the RGB fade controller.
package rgb_pkg;

  localparam logic [7:0] CHAN_MAX = 8'hFF;
  localparam logic [7:0] CHAN_MIN = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // dir: 0 = fading up towards CHAN_MAX, 1 = fading down towards CHAN_MIN.
  function automatic logic is_limit(input logic [7:0] v, input logic dir);
    return dir ? (v == CHAN_MIN) : (v == CHAN_MAX);
  endfunction

endpackage

// File: rtl/rgb_sat_step.sv
// One channel's saturating step: 9-bit add/subtract clamped to the 8-bit range.
module rgb_sat_step
  import rgb_pkg::*;
(
  input  logic [7:0] value_i,
  input  logic [7:0] step_i,
  input  logic       dir_i,
  output logic [7:0] next_o,
  output logic       at_limit_o
);

  logic [8:0] sum;
  logic [8:0] diff;

  always_comb begin
    sum        = {1'b0, value_i} + {1'b0, step_i};
    diff       = {1'b0, value_i} - {1'b0, step_i};
    next_o     = value_i;
    // Carry out of the add or borrow out of the subtract means saturation.
    if (!dir_i) next_o = sum[8] ? CHAN_MAX : sum[7:0];
    else        next_o = diff[8] ? CHAN_MIN : diff[7:0];
    at_limit_o = is_limit(next_o, dir_i);
  end

endmodule

// File: rtl/rgb_fade_controller.sv
// RGB fade FSM: steps all three channels every TICK_DIV cycles until they saturate.
// Define RGB_FADE_PINGPONG_EN to bounce between limits instead of finishing.
module rgb_fade_controller
  import rgb_pkg::*;
#(
  parameter logic [7:0]  STEP     = 8'd10,
  parameter int unsigned TICK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       dir,
  input  logic       abort,
  input  logic [7:0] r_in,
  input  logic [7:0] g_in,
  input  logic [7:0] b_in,
  output logic [7:0] r_out,
  output logic [7:0] g_out,
  output logic [7:0] b_out,
  output logic       busy,
  output logic       done
);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        dir_q, dir_d;
  logic [7:0]  r_q, r_d, g_q, g_d, b_q, b_d;
  logic [7:0]  r_nxt, g_nxt, b_nxt;
  logic        r_lim, g_lim, b_lim;
  logic        tick;
  logic        in_at_lim;

  rgb_sat_step u_step_r (.value_i(r_q), .step_i(STEP), .dir_i(dir_q), .next_o(r_nxt), .at_limit_o(r_lim));
  rgb_sat_step u_step_g (.value_i(g_q), .step_i(STEP), .dir_i(dir_q), .next_o(g_nxt), .at_limit_o(g_lim));
  rgb_sat_step u_step_b (.value_i(b_q), .step_i(STEP), .dir_i(dir_q), .next_o(b_nxt), .at_limit_o(b_lim));

  assign tick      = (cnt_q == 16'(TICK_DIV - 32'd1));
  assign in_at_lim = is_limit(r_in, dir) && is_limit(g_in, dir) && is_limit(b_in, dir);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    r_d     = r_q;
    g_d     = g_q;
    b_d     = b_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          r_d     = r_in;
          g_d     = g_in;
          b_d     = b_in;
          dir_d   = dir;
          cnt_d   = '0;
          state_d = ST_RUN;
          if (in_at_lim) begin
`ifdef RGB_FADE_PINGPONG_EN
            dir_d   = ~dir;
`else
            state_d = ST_DONE;
`endif
          end
        end
      end
      ST_RUN: begin
        // Abort outranks a coincident tick: no update on that edge.
        if (abort) begin
          state_d = ST_IDLE;
        end else if (tick) begin
          cnt_d = '0;
          r_d   = r_nxt;
          g_d   = g_nxt;
          b_d   = b_nxt;
          if (r_lim && g_lim && b_lim) begin
`ifdef RGB_FADE_PINGPONG_EN
            dir_d   = ~dir_q;
`else
            state_d = ST_DONE;
`endif
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
    end
  end

  assign r_out = r_q;
  assign g_out = g_q;
  assign b_out = b_q;
  assign busy  = (state_q == ST_RUN);
  assign done  = (state_q == ST_DONE);

endmodule

// File: tb/tb_rgb_fade_controller.sv
// Directed bench for rgb_fade_controller with a queue of expected per-step colors.
// Honours RGB_FADE_PINGPONG_EN the same way as the design.
module tb_rgb_fade_controller;

  localparam logic [7:0]  STEP     = 8'd10;
  localparam int unsigned TICK_DIV = 4;

  logic       clk = 1'b0;
  logic       rst, start, dir, abort;
  logic [7:0] r_in, g_in, b_in;
  logic [7:0] r_out, g_out, b_out;
  logic       busy, done;

  int checks   = 0;
  int failures = 0;
  logic [23:0] sb[$];

  always #5 clk = ~clk;

  rgb_fade_controller #(.STEP(STEP), .TICK_DIV(TICK_DIV)) dut (
    .clk(clk), .rst(rst), .start(start), .dir(dir), .abort(abort),
    .r_in(r_in), .g_in(g_in), .b_in(b_in),
    .r_out(r_out), .g_out(g_out), .b_out(b_out),
    .busy(busy), .done(done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int nx(input int x, input logic d);
    if (!d) return (x + int'(STEP) > 255) ? 255 : x + int'(STEP);
    return (x < int'(STEP)) ? 0 : x - int'(STEP);
  endfunction

  function automatic bit lim3(input int r, input int g, input int b, input logic d);
    if (d) return (r == 0) && (g == 0) && (b == 0);
    return (r == 255) && (g == 255) && (b == 255);
  endfunction

  // Expected color after each update, in order.
  task automatic push_fade(input int r, input int g, input int b, input logic d, input int n_max);
    int   cr = r, cg = g, cb = b;
    logic cd = d;
    if (lim3(cr, cg, cb, cd)) begin
`ifdef RGB_FADE_PINGPONG_EN
      cd = ~cd;
`else
      return;
`endif
    end
    for (int i = 0; i < n_max; i++) begin
      cr = nx(cr, cd);
      cg = nx(cg, cd);
      cb = nx(cb, cd);
      sb.push_back({8'(cr), 8'(cg), 8'(cb)});
      if (lim3(cr, cg, cb, cd)) begin
`ifdef RGB_FADE_PINGPONG_EN
        cd = ~cd;
`else
        break;
`endif
      end
    end
  endtask

  task automatic do_fade(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                         input logic d, input int n_max, input string tag);
    logic [23:0] exp;
    exp = {r, g, b};
    push_fade(int'(r), int'(g), int'(b), d, n_max);
    r_in = r; g_in = g; b_in = b; dir = d; start = 1'b1;
    step();
    check({tag, "_cap"}, {r_out, g_out, b_out}, exp);
    // Keep start high with different data for one more edge: must be ignored.
    r_in = 8'h55; g_in = 8'h55; b_in = 8'h55; dir = ~d;
`ifndef RGB_FADE_PINGPONG_EN
    if (sb.size() == 0) begin
      check({tag, "_nolim_busydone"}, {busy, done}, 2'b01);
      step();
      start = 1'b0;
      check({tag, "_nolim_after"}, {busy, done}, 2'b00);
      check({tag, "_nolim_rgb"}, {r_out, g_out, b_out}, exp);
      return;
    end
`endif
    check({tag, "_busy"}, {busy, done}, 2'b10);
    while (sb.size() > 0) begin
      exp = sb.pop_front();
      for (int k = 0; k < int'(TICK_DIV); k++) begin
        step();
        start = 1'b0;
      end
      check({tag, "_rgb"}, {r_out, g_out, b_out}, exp);
      if (sb.size() > 0) check({tag, "_run"}, {busy, done}, 2'b10);
    end
`ifndef RGB_FADE_PINGPONG_EN
    check({tag, "_done"}, {busy, done}, 2'b01);
    step();
    check({tag, "_done_once"}, {busy, done}, 2'b00);
    check({tag, "_hold"}, {r_out, g_out, b_out}, exp);
`else
    check({tag, "_pp_run"}, {busy, done}, 2'b10);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check({tag, "_pp_abort"}, {busy, done}, 2'b00);
    check({tag, "_pp_hold"}, {r_out, g_out, b_out}, exp);
`endif
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; dir = 1'b0; abort = 1'b0;
    r_in = '0; g_in = '0; b_in = '0;
    step();
    step();
    check("rst_rgb", {r_out, g_out, b_out}, 24'h000000);
    check("rst_busydone", {busy, done}, 2'b00);
    rst = 1'b0;
    step();
    check("idle_busydone", {busy, done}, 2'b00);

    do_fade(8'd250, 8'd0, 8'd128, 1'b0, 40, "up");
    do_fade(8'd5, 8'd20, 8'd0, 1'b1, 40, "down");
    do_fade(8'd255, 8'd255, 8'd255, 1'b0, 1, "lim");

    // Abort on the edge that would carry the first update.
    r_in = 8'd100; g_in = 8'd100; b_in = 8'd100; dir = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < int'(TICK_DIV) - 1; k++) step();
    check("abort_pre", {busy, r_out, g_out, b_out}, {1'b1, 24'h646464});
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_rgb", {r_out, g_out, b_out}, 24'h646464);
    check("abort_busydone", {busy, done}, 2'b00);
    step();
    check("abort_nodone", {busy, done}, 2'b00);

    // Reset mid-fade, with start and abort also high.
    r_in = 8'd10; g_in = 8'd10; b_in = 8'd10; dir = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 2 * int'(TICK_DIV); k++) step();
    check("midrst_pre", {r_out, g_out, b_out}, 24'h1E1E1E);
    rst = 1'b1; start = 1'b1; abort = 1'b1;
    step();
    rst = 1'b0; start = 1'b0; abort = 1'b0;
    check("midrst_rgb", {r_out, g_out, b_out}, 24'h000000);
    check("midrst_busydone", {busy, done}, 2'b00);
    step();
    check("midrst_idle", {busy, done, r_out, g_out, b_out}, 26'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
